cond_unit: RTL and testbench
============================

COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; the clock and reset ports are decided as listed in REQ-002 and REQ-003.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; asserted low clears all state immediately.
REQ-004 InstrValid  in  1  one-cycle pulse; captures Cond, FlagW, PCS, RegW, MemW, NoWrite for a new instruction.
REQ-005 Cond  in  4  ARM condition field of the instruction.
REQ-006 FlagW  in  2  flag write request: [1] updates N,Z; [0] updates C,V.
REQ-007 PCS, RegW, MemW, NoWrite  in  1 each  decoder requests: PC write, register write, memory write, suppress register write.
REQ-008 FlagUpd  in  1  one-cycle pulse marking the cycle in which ALUFlags is valid.
REQ-009 ALUFlags  in  4  {N,Z,C,V} from the ALU.
REQ-010 CondEx  out  1  registered result of the condition check for the held instruction.
REQ-011 PCSrc, RegWrite, MemWrite  out  1 each  gated write enables.
REQ-012 Flags  out  4  architectural {N,Z,C,V} register.
REQ-013 Busy  out  1  high while an instruction is held (state HELD).

Function
REQ-014 FSM: IDLE, HELD; IDLE->HELD on InstrValid; HELD->HELD on InstrValid (new capture replaces old); HELD->IDLE on FlagUpd without InstrValid.
REQ-015 On InstrValid the block SHALL evaluate Cond against the current Flags register (pre-update value) and register the result into CondEx at the same edge.
REQ-016 Conditions: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 evaluates to 0.
REQ-017 PCSrc = PCS_held & CondEx; RegWrite = RegW_held & CondEx & !NoWrite_held; MemWrite = MemW_held & CondEx; all forced 0 in IDLE.
REQ-018 On FlagUpd in HELD with CondEx=1: Flags[3:2] <= ALUFlags[3:2] if FlagW_held[1]; Flags[1:0] <= ALUFlags[1:0] if FlagW_held[0]; otherwise Flags hold.
REQ-019 FlagUpd in IDLE SHALL be ignored (no flag change).
REQ-020 InstrValid and FlagUpd in the same cycle: flag update uses old held FlagW/CondEx; new condition uses old Flags; new instruction captured; state remains HELD.
REQ-021 Latency: CondEx and gated enables valid one cycle after InstrValid; Flags visible one cycle after FlagUpd.

Reset
REQ-022 While reset is low: state IDLE, Flags=4'b0000, CondEx=0, held fields 0, Busy=0, PCSrc/RegWrite/MemWrite=0.
REQ-023 Reset mid-instruction SHALL discard the held instruction; a FlagUpd in the first cycle after release is ignored.

Configuration
REQ-024 Macro COND_FLAG_SHADOW_EN SHALL add inputs FlagSave, FlagRestore (1 bit each) and a 4-bit shadow register reset to 0.
REQ-025 With COND_FLAG_SHADOW_EN: FlagSave copies Flags to shadow; FlagRestore loads Flags from shadow with priority over FlagUpd; simultaneous FlagSave and FlagRestore swaps values.
REQ-026 Without COND_FLAG_SHADOW_EN the ports and shadow register SHALL not exist and behaviour is REQ-014..REQ-023 exactly.

Structure
REQ-027 Shared package cond_pkg SHALL hold the 4-bit condition code constants (EQ..AL, NV=1111), flag bit indices (N=3,Z=2,C=1,V=0) and FSM state encoding.
REQ-028 The condition evaluator SHALL be a combinational sub-module cond_eval (Cond, Flags -> pass).

Verification
REQ-029 Reset low, Flags preset by prior updates -> Flags=0000, CondEx=0, Busy=0 immediately, before any clock edge.
REQ-030 Flags=0100, InstrValid with Cond=0000 (EQ), RegW=1 -> next cycle CondEx=1, RegWrite=1; same with Cond=0001 (NE) -> CondEx=0, RegWrite=0.
REQ-031 Held AL instr, FlagW=10, FlagUpd with ALUFlags=1111 from Flags=0000 -> Flags=1100; FlagW=01 -> Flags=0011.
REQ-032 Held instr with CondEx=0, FlagW=11, FlagUpd ALUFlags=1111 -> Flags unchanged; Cond=1111 with Flags=0000 -> CondEx=0.
REQ-033 Flags=1000, InstrValid(Cond=1010 GE) together with FlagUpd(ALUFlags=1001, prior FlagW=11, CondEx=1) -> CondEx=0 (evaluated on 1000), Flags=1001.
REQ-034 COND_FLAG_SHADOW_EN: Flags=0110, FlagSave; then update to 1001; FlagRestore with FlagUpd same cycle -> Flags=0110.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared constants for the ARM-style condition unit: condition codes, flag bit
// positions and FSM state encoding.
package cond_pkg;

    localparam int unsigned COND_W  = 4;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned FLAGW_W = 2;

    localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
    localparam logic [COND_W-1:0] COND_NE = 4'b0001;
    localparam logic [COND_W-1:0] COND_CS = 4'b0010;
    localparam logic [COND_W-1:0] COND_CC = 4'b0011;
    localparam logic [COND_W-1:0] COND_MI = 4'b0100;
    localparam logic [COND_W-1:0] COND_PL = 4'b0101;
    localparam logic [COND_W-1:0] COND_VS = 4'b0110;
    localparam logic [COND_W-1:0] COND_VC = 4'b0111;
    localparam logic [COND_W-1:0] COND_HI = 4'b1000;
    localparam logic [COND_W-1:0] COND_LS = 4'b1001;
    localparam logic [COND_W-1:0] COND_GE = 4'b1010;
    localparam logic [COND_W-1:0] COND_LT = 4'b1011;
    localparam logic [COND_W-1:0] COND_GT = 4'b1100;
    localparam logic [COND_W-1:0] COND_LE = 4'b1101;
    localparam logic [COND_W-1:0] COND_AL = 4'b1110;
    localparam logic [COND_W-1:0] COND_NV = 4'b1111;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of a 4-bit condition field against {N,Z,C,V}.
module cond_eval
    import cond_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Condition unit: holds one decoded instruction, gates its write enables by the
// condition check and maintains the NZCV flag register.
// Optional flag shadow register enabled by defining COND_FLAG_SHADOW_EN.
module cond_unit
    import cond_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
`ifdef COND_FLAG_SHADOW_EN
    input  logic                FlagSave,
    input  logic                FlagRestore,
`endif
    input  logic                InstrValid,
    input  logic [COND_W-1:0]   Cond,
    input  logic [FLAGW_W-1:0]  FlagW,
    input  logic                PCS,
    input  logic                RegW,
    input  logic                MemW,
    input  logic                NoWrite,
    input  logic                FlagUpd,
    input  logic [FLAG_W-1:0]   ALUFlags,
    output logic                CondEx,
    output logic                PCSrc,
    output logic                RegWrite,
    output logic                MemWrite,
    output logic [FLAG_W-1:0]   Flags,
    output logic                Busy
);

    state_t               state_q, state_d;
    logic [FLAG_W-1:0]    flags_q, flags_d, flags_upd;
    logic [FLAGW_W-1:0]   flagw_q, flagw_d;
    logic                 condex_q, condex_d;
    logic                 pcsrc_q, pcsrc_d;
    logic                 regwrite_q, regwrite_d;
    logic                 memwrite_q, memwrite_d;
    logic                 busy_q, busy_d;
    logic                 pass;
`ifdef COND_FLAG_SHADOW_EN
    logic [FLAG_W-1:0]    shadow_q, shadow_d;
`endif

    // New instructions are always judged against the pre-update flag register.
    cond_eval u_cond_eval (
        .cond  (Cond),
        .flags (flags_q),
        .pass  (pass)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            flags_q    <= '0;
            flagw_q    <= '0;
            condex_q   <= 1'b0;
            pcsrc_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef COND_FLAG_SHADOW_EN
            shadow_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            flags_q    <= flags_d;
            flagw_q    <= flagw_d;
            condex_q   <= condex_d;
            pcsrc_q    <= pcsrc_d;
            regwrite_q <= regwrite_d;
            memwrite_q <= memwrite_d;
            busy_q     <= busy_d;
`ifdef COND_FLAG_SHADOW_EN
            shadow_q   <= shadow_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        flags_upd  = flags_q;
        flagw_d    = flagw_q;
        condex_d   = condex_q;
        pcsrc_d    = pcsrc_q;
        regwrite_d = regwrite_q;
        memwrite_d = memwrite_q;

        unique case (state_q)
            ST_IDLE: if (InstrValid) state_d = ST_HELD;
            ST_HELD: if (FlagUpd && !InstrValid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Flag writeback is owned by the instruction currently held.
        if (state_q == ST_HELD && FlagUpd && condex_q) begin
            if (flagw_q[1]) begin
                flags_upd[FLAG_N] = ALUFlags[FLAG_N];
                flags_upd[FLAG_Z] = ALUFlags[FLAG_Z];
            end
            if (flagw_q[0]) begin
                flags_upd[FLAG_C] = ALUFlags[FLAG_C];
                flags_upd[FLAG_V] = ALUFlags[FLAG_V];
            end
        end

        if (InstrValid) begin
            flagw_d    = FlagW;
            condex_d   = pass;
            pcsrc_d    = PCS & pass;
            regwrite_d = RegW & pass & !NoWrite;
            memwrite_d = MemW & pass;
        end else if (state_d == ST_IDLE) begin
            pcsrc_d    = 1'b0;
            regwrite_d = 1'b0;
            memwrite_d = 1'b0;
        end

        busy_d = (state_d == ST_HELD);

`ifdef COND_FLAG_SHADOW_EN
        // Save and restore both sample the old values, so together they swap.
        shadow_d = FlagSave ? flags_q : shadow_q;
        flags_d  = FlagRestore ? shadow_q : flags_upd;
`else
        flags_d  = flags_upd;
`endif
    end

    assign CondEx   = condex_q;
    assign PCSrc    = pcsrc_q;
    assign RegWrite = regwrite_q;
    assign MemWrite = memwrite_q;
    assign Flags    = flags_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: directed scenarios plus randomized traffic checked every
// cycle against a behavioural model. Shadow checks need COND_FLAG_SHADOW_EN.
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       InstrValid;
    logic [3:0] Cond;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, NoWrite;
    logic       FlagUpd;
    logic [3:0] ALUFlags;
    logic       CondEx, PCSrc, RegWrite, MemWrite, Busy;
    logic [3:0] Flags;
`ifdef COND_FLAG_SHADOW_EN
    logic       FlagSave, FlagRestore;
`endif

    int checks = 0;
    int passes = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    cond_unit dut (
        .clk        (clk),
        .reset      (reset),
`ifdef COND_FLAG_SHADOW_EN
        .FlagSave   (FlagSave),
        .FlagRestore(FlagRestore),
`endif
        .InstrValid (InstrValid),
        .Cond       (Cond),
        .FlagW      (FlagW),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .NoWrite    (NoWrite),
        .FlagUpd    (FlagUpd),
        .ALUFlags   (ALUFlags),
        .CondEx     (CondEx),
        .PCSrc      (PCSrc),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .Flags      (Flags),
        .Busy       (Busy)
    );

    // Condition codes come in pairs: odd code is the negation of the even one.
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'd15) return 1'b0;
        if (c == 4'd14) return 1'b1;
        return c[0] ? !base : base;
    endfunction

    // Reference model state.
    logic       m_busy, m_condex, m_pcs, m_regw, m_memw, m_nowr;
    logic [1:0] m_flagw;
    logic [3:0] m_flags, m_shadow;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 0; m_condex <= 0; m_pcs <= 0; m_regw <= 0; m_memw <= 0;
            m_nowr <= 0; m_flagw <= 0; m_flags <= 0; m_shadow <= 0;
        end else begin
            logic [3:0] nf;
            nf = m_flags;
            if (m_busy && m_condex && FlagUpd)
                nf = {m_flagw[1] ? ALUFlags[3:2] : m_flags[3:2],
                      m_flagw[0] ? ALUFlags[1:0] : m_flags[1:0]};
`ifdef COND_FLAG_SHADOW_EN
            if (FlagRestore) nf = m_shadow;
            if (FlagSave) m_shadow <= m_flags;
`endif
            m_flags <= nf;
            if (InstrValid) begin
                m_busy   <= 1'b1;
                m_condex <= cond_holds(Cond, m_flags);
                m_flagw  <= FlagW;
                m_pcs    <= PCS;
                m_regw   <= RegW;
                m_memw   <= MemW;
                m_nowr   <= NoWrite;
            end else if (FlagUpd) begin
                m_busy <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("flags",    Flags,         m_flags);
            check("condex",   4'(CondEx),    4'(m_condex));
            check("busy",     4'(Busy),      4'(m_busy));
            check("pcsrc",    4'(PCSrc),     4'(m_busy & m_pcs & m_condex));
            check("regwrite", 4'(RegWrite),  4'(m_busy & m_regw & m_condex & !m_nowr));
            check("memwrite", 4'(MemWrite),  4'(m_busy & m_memw & m_condex));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] c, input logic [1:0] fw, input logic rw);
        InstrValid = 1'b1; Cond = c; FlagW = fw; RegW = rw;
        step();
        InstrValid = 1'b0; RegW = 1'b0;
    endtask

    task automatic upd(input logic [3:0] alu);
        FlagUpd = 1'b1; ALUFlags = alu;
        step();
        FlagUpd = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        InstrValid = 0; Cond = 0; FlagW = 0; PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
        FlagUpd = 0; ALUFlags = 0;
`ifdef COND_FLAG_SHADOW_EN
        FlagSave = 0; FlagRestore = 0;
`endif
        repeat (2) step();
        check("rst_busy",  4'(Busy),   4'b0);
        check("rst_flags", Flags,      4'b0000);
        reset = 1'b1;
        cmp_en = 1'b1;

        // N,Z only, then reset while an AL instruction is held
        issue(4'b1110, 2'b10, 1'b0);
        upd(4'b1111);
        check("nz_update", Flags, 4'b1100);
        issue(4'b1110, 2'b10, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("async_rst_flags",  Flags,       4'b0000);
        check("async_rst_condex", 4'(CondEx),  4'b0);
        check("async_rst_busy",   4'(Busy),    4'b0);
        step();
        reset = 1'b1;
        upd(4'b1111);
        check("post_rst_flagupd", Flags, 4'b0000);

        // C,V only
        issue(4'b1110, 2'b01, 1'b0);
        upd(4'b1111);
        check("cv_update", Flags, 4'b0011);

        // EQ / NE against Flags=0100
        issue(4'b1110, 2'b11, 1'b0);
        upd(4'b0100);
        issue(4'b0000, 2'b00, 1'b1);
        check("eq_condex",   4'(CondEx),   4'b1);
        check("eq_regwrite", 4'(RegWrite), 4'b1);
        issue(4'b0001, 2'b11, 1'b1);
        check("ne_condex",   4'(CondEx),   4'b0);
        check("ne_regwrite", 4'(RegWrite), 4'b0);
        upd(4'b1111);
        check("failed_cond_no_flags", Flags, 4'b0100);

        // NV never passes
        issue(4'b1110, 2'b11, 1'b0);
        upd(4'b0000);
        issue(4'b1111, 2'b00, 1'b0);
        check("nv_condex", 4'(CondEx), 4'b0);

        // Simultaneous InstrValid(GE) and FlagUpd
        issue(4'b1110, 2'b11, 1'b0);
        upd(4'b1000);
        issue(4'b1110, 2'b11, 1'b0);
        InstrValid = 1'b1; Cond = 4'b1010; FlagW = 2'b00;
        FlagUpd = 1'b1; ALUFlags = 4'b1001;
        step();
        InstrValid = 1'b0; FlagUpd = 1'b0;
        check("simul_condex", 4'(CondEx), 4'b0);
        check("simul_flags",  Flags,      4'b1001);
        check("simul_busy",   4'(Busy),   4'b1);

`ifdef COND_FLAG_SHADOW_EN
        issue(4'b1110, 2'b11, 1'b0);
        upd(4'b0110);
        FlagSave = 1'b1; step(); FlagSave = 1'b0;
        issue(4'b1110, 2'b11, 1'b0);
        upd(4'b1001);
        check("shadow_pre", Flags, 4'b1001);
        issue(4'b1110, 2'b11, 1'b0);
        FlagRestore = 1'b1; FlagUpd = 1'b1; ALUFlags = 4'b1111;
        step();
        FlagRestore = 1'b0; FlagUpd = 1'b0;
        check("shadow_restore", Flags, 4'b0110);
`endif

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            InstrValid = ($urandom % 3) == 0;
            Cond       = 4'($urandom);
            FlagW      = 2'($urandom);
            PCS        = 1'($urandom);
            RegW       = 1'($urandom);
            MemW       = 1'($urandom);
            NoWrite    = 1'($urandom);
            FlagUpd    = ($urandom % 3) == 0;
            ALUFlags   = 4'($urandom);
`ifdef COND_FLAG_SHADOW_EN
            FlagSave    = ($urandom % 8) == 0;
            FlagRestore = ($urandom % 8) == 0;
`endif
            if (($urandom % 250) == 0) begin
                #2 reset = 1'b0;
                step();
                reset = 1'b1;
            end else begin
                step();
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
